// File: rtl/sprite_drawer_if.sv
// Request/response and ROM/VGA bundle between the movement FSM, the two sprite ROMs, the VGA write port and sprite_drawer.
// Requests are one-cycle pulses; the drawer answers each accepted request with exactly one one-cycle done pulse.
interface sprite_drawer_if #(
  parameter int COLOUR_W = 3,
  parameter int CADDR_W  = 6
);
  logic                drawBG;
  logic                drawChar;
  logic [8:0]          xCoordinate;
  logic [7:0]          yCoordinate;
  logic [16:0]         bgAddr;
  logic [COLOUR_W-1:0] bgColour;
  logic [CADDR_W-1:0]  charAddr;
  logic [COLOUR_W-1:0] charColour;
  logic [8:0]          xOut;
  logic [7:0]          yOut;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                doneBG;
  logic                doneChar;
  logic                busy;
  logic [2:0]          dbgState;

  modport master (
    output drawBG, drawChar, xCoordinate, yCoordinate, bgColour, charColour,
    input  bgAddr, charAddr, xOut, yOut, colour, plot, doneBG, doneChar, busy, dbgState
  );

  modport slave (
    input  drawBG, drawChar, xCoordinate, yCoordinate, bgColour, charColour,
    output bgAddr, charAddr, xOut, yOut, colour, plot, doneBG, doneChar, busy, dbgState
  );
endinterface

// File: rtl/sprite_drawer.sv
// Streams one sprite-sized rectangle of background or character pixels to the VGA write port,
// one pixel per cycle, with clipping at the screen edge and a fixed request-to-done latency.
module sprite_drawer #(
  parameter int                  SPR_W       = 8,
  parameter int                  SPR_H       = 8,
  parameter int                  COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = '0,
  parameter int                  SCREEN_W    = 320,
  parameter int                  SCREEN_H    = 240
) (
  input logic           clock,
  input logic           resetn,
  sprite_drawer_if.slave bus
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPR_H - 1);
  localparam logic [9:0]       X_LIM   = 10'(SCREEN_W);
  localparam logic [8:0]       Y_LIM   = 9'(SCREEN_H);
  localparam logic             MODE_BG   = 1'b0;
  localparam logic             MODE_CHAR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [8:0]       r_x0;
  logic [7:0]       r_y0;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_pend_bg;
  logic             r_pend_ch;
  logic             r_busy;
  logic             r_done_bg;
  logic             r_done_ch;

  logic             r_p_valid;
  logic             r_p_mode;
  logic [8:0]       r_p_x;
  logic [7:0]       r_p_y;

  logic [9:0]          w_x_sum;
  logic [8:0]          w_y_sum;
  logic                w_in_range;
  logic                w_issue;
  logic                w_last;
  logic                w_plot;
  logic [COLOUR_W-1:0] w_rom;

  // Extra top bit on each sum so an off-screen position can never wrap back onto the screen.
  assign w_x_sum    = {1'b0, r_x0} + 10'(r_col);
  assign w_y_sum    = {1'b0, r_y0} + 9'(r_row);
  assign w_in_range = (w_x_sum < X_LIM) && (w_y_sum < Y_LIM);
  assign w_issue    = (r_state == S_SCAN);
  assign w_last     = (r_col == COL_MAX) && (r_row == ROW_MAX);

  assign bus.bgAddr   = (w_issue && w_in_range) ?
                        (17'(w_y_sum) * 17'(SCREEN_W) + 17'(w_x_sum)) : 17'd0;
  assign bus.charAddr = w_issue ? {r_row, r_col} : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_mode    <= MODE_BG;
      r_x0      <= '0;
      r_y0      <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_pend_bg <= 1'b0;
      r_pend_ch <= 1'b0;
      r_busy    <= 1'b0;
      r_done_bg <= 1'b0;
      r_done_ch <= 1'b0;
    end else begin
      // A request is held pending until its own LOAD; pulses of the same type collapse into one.
      r_pend_bg <= (r_pend_bg && !(r_state == S_LOAD && r_mode == MODE_BG))   || bus.drawBG;
      r_pend_ch <= (r_pend_ch && !(r_state == S_LOAD && r_mode == MODE_CHAR)) || bus.drawChar;
      case (r_state)
        S_IDLE: begin
          if (bus.drawBG || r_pend_bg) begin
            r_mode  <= MODE_BG;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end else if (bus.drawChar || r_pend_ch) begin
            r_mode  <= MODE_CHAR;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_x0    <= bus.xCoordinate;
          r_y0    <= bus.yCoordinate;
          r_col   <= '0;
          r_row   <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_col <= r_col + 1'b1;
          if (r_col == COL_MAX) r_row <= r_row + 1'b1;
          if (w_last) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_done_bg <= (r_mode == MODE_BG);
          r_done_ch <= (r_mode == MODE_CHAR);
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_done_bg <= 1'b0;
          r_done_ch <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Alignment stage: lines up the issued pixel position and mode with the ROM's registered read data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_p_valid <= 1'b0;
      r_p_mode  <= MODE_BG;
      r_p_x     <= '0;
      r_p_y     <= '0;
    end else begin
      r_p_valid <= w_issue && w_in_range;
      r_p_mode  <= r_mode;
      r_p_x     <= w_x_sum[8:0];
      r_p_y     <= w_y_sum[7:0];
    end
  end

  assign w_rom  = (r_p_mode == MODE_CHAR) ? bus.charColour : bus.bgColour;
  assign w_plot = r_p_valid && ((r_p_mode == MODE_BG) || (bus.charColour != TRANSPARENT));

  assign bus.plot     = w_plot;
  assign bus.colour   = w_plot ? w_rom : '0;
  assign bus.xOut     = r_p_x;
  assign bus.yOut     = r_p_y;
  assign bus.doneBG   = r_done_bg;
  assign bus.doneChar = r_done_ch;
  assign bus.busy     = r_busy;
  assign bus.dbgState = r_state;

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer: ROM models, an expected-pixel queue and fixed cycle timelines per scenario.
module tb_sprite_drawer;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sprite_drawer_if #(.COLOUR_W(3), .CADDR_W(6)) bus();

  sprite_drawer #(
    .SPR_W(8), .SPR_H(8), .COLOUR_W(3), .TRANSPARENT(3'b000),
    .SCREEN_W(320), .SCREEN_H(240)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int plot_cnt = 0;
  int done_bg_cnt = 0;
  int done_ch_cnt = 0;
  logic tmode = 1'b1;  // 1: char ROM transparent at even addresses; 0: fully opaque
  logic [19:0] exp_q[$];

  function automatic logic [2:0] char_rom(input logic [5:0] a);
    if (tmode) return a[0] ? a[2:0] : 3'b000;
    return a[2:0] | 3'b001;
  endfunction

  // Synchronous-read ROMs: data for an address appears the cycle after it is presented.
  always @(posedge clock) begin
    bus.bgColour   <= bus.bgAddr[2:0];
    bus.charColour <= char_rom(bus.charAddr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_bg(input int x0, input int y0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int x = x0 + c;
        int y = y0 + r;
        if (x < 320 && y < 240) exp_q.push_back({9'(x), 8'(y), 3'((y * 320 + x) % 8)});
      end
  endtask

  task automatic push_ch(input int x0, input int y0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int x = x0 + c;
        int y = y0 + r;
        int a = r * 8 + c;
        int col;
        if (tmode) col = (a % 2 == 1) ? (a % 8) : 0;
        else       col = (a % 8) | 1;
        if (x < 320 && y < 240 && col != 0) exp_q.push_back({9'(x), 8'(y), 3'(col)});
      end
  endtask

  task automatic clear_stats();
    plot_cnt = 0;
    done_bg_cnt = 0;
    done_ch_cnt = 0;
    exp_q.delete();
  endtask

  task automatic step();
    logic [19:0] e;
    @(negedge clock);
    bus.drawBG   = 1'b0;
    bus.drawChar = 1'b0;
    cyc++;
    if (bus.plot === 1'b1) begin
      plot_cnt++;
      if (exp_q.size() == 0)
        chk("unexpected_pixel", {12'd0, bus.xOut, bus.yOut, bus.colour}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("pixel", {12'd0, bus.xOut, bus.yOut, bus.colour}, {12'd0, e});
      end
    end
    if (bus.doneBG === 1'b1)   done_bg_cnt++;
    if (bus.doneChar === 1'b1) done_ch_cnt++;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse(input logic bg, input logic ch);
    bus.drawBG   = bg;
    bus.drawChar = ch;
    cyc = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.drawBG = 1'b0;
    bus.drawChar = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    bus.drawBG = 1'b0;
    bus.drawChar = 1'b0;
    bus.xCoordinate = '0;
    bus.yCoordinate = '0;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_colour", 32'(bus.colour), 0);
    chk("rst_done", {30'd0, bus.doneBG, bus.doneChar}, 0);
    chk("rst_xy", {15'd0, bus.xOut, bus.yOut}, 0);
    chk("rst_bgaddr", 32'(bus.bgAddr), 0);
    chk("rst_state", 32'(bus.dbgState), 0);

    // 1: background redraw at (96,222)
    clear_stats();
    bus.xCoordinate = 9'd96;
    bus.yCoordinate = 8'd222;
    push_bg(96, 222);
    pulse(1'b1, 1'b0);
    step();
    chk("s1_busy_rise", 32'(bus.busy), 1);
    chk("s1_no_plot_load", 32'(bus.plot), 0);
    step();
    chk("s1_bgaddr_first", 32'(bus.bgAddr), 32'd71136);
    run_until(66);
    chk("s1_no_done_early", 32'(done_bg_cnt), 0);
    step();
    chk("s1_doneBG_at_67", 32'(bus.doneBG), 1);
    chk("s1_plot_in_done", 32'(bus.plot), 0);
    step();
    chk("s1_busy_fall", 32'(bus.busy), 0);
    chk("s1_plots", 32'(plot_cnt), 64);
    chk("s1_queue_left", 32'(exp_q.size()), 0);
    chk("s1_done_counts", {done_bg_cnt[15:0], done_ch_cnt[15:0]}, {16'd1, 16'd0});

    // 2: character at (10,10), transparent at even ROM addresses
    clear_stats();
    tmode = 1'b1;
    bus.xCoordinate = 9'd10;
    bus.yCoordinate = 8'd10;
    push_ch(10, 10);
    pulse(1'b0, 1'b1);
    run_until(67);
    chk("s2_doneChar_at_67", 32'(bus.doneChar), 1);
    step();
    chk("s2_plots", 32'(plot_cnt), 32);
    chk("s2_queue_left", 32'(exp_q.size()), 0);
    chk("s2_done_counts", {done_bg_cnt[15:0], done_ch_cnt[15:0]}, {16'd0, 16'd1});

    // 3: simultaneous requests, BG first then CHAR back-to-back
    clear_stats();
    bus.xCoordinate = 9'd50;
    bus.yCoordinate = 8'd60;
    push_bg(50, 60);
    push_ch(50, 60);
    pulse(1'b1, 1'b1);
    run_until(67);
    chk("s3_doneBG_at_67", 32'(bus.doneBG), 1);
    run_until(135);
    chk("s3_doneChar_at_135", 32'(bus.doneChar), 1);
    chk("s3_plots", 32'(plot_cnt), 96);
    run_until(150);
    chk("s3_queue_left", 32'(exp_q.size()), 0);
    chk("s3_done_counts", {done_bg_cnt[15:0], done_ch_cnt[15:0]}, {16'd1, 16'd1});

    // 4: clipping at the bottom-right corner, opaque character
    clear_stats();
    tmode = 1'b0;
    bus.xCoordinate = 9'd316;
    bus.yCoordinate = 8'd236;
    push_ch(316, 236);
    pulse(1'b0, 1'b1);
    run_until(67);
    chk("s4_doneChar_at_67", 32'(bus.doneChar), 1);
    step();
    chk("s4_plots", 32'(plot_cnt), 16);
    chk("s4_queue_left", 32'(exp_q.size()), 0);

    // 5: reset in the middle of a background redraw
    clear_stats();
    bus.xCoordinate = 9'd96;
    bus.yCoordinate = 8'd222;
    push_bg(96, 222);
    pulse(1'b1, 1'b0);
    run_until(30);
    resetn = 1'b0;
    #1;
    chk("s5_plot_async", 32'(bus.plot), 0);
    chk("s5_busy_async", 32'(bus.busy), 0);
    chk("s5_done_async", {30'd0, bus.doneBG, bus.doneChar}, 0);
    chk("s5_state_async", 32'(bus.dbgState), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    clear_stats();
    cyc = 0;
    run_until(80);
    chk("s5_no_done_after", {done_bg_cnt[15:0], done_ch_cnt[15:0]}, 0);
    chk("s5_no_plot_after", 32'(plot_cnt), 0);
    push_bg(96, 222);
    pulse(1'b1, 1'b0);
    step();
    chk("s5_busy_rise", 32'(bus.busy), 1);
    step();
    chk("s5_bgaddr_first", 32'(bus.bgAddr), 32'd71136);
    run_until(67);
    chk("s5_doneBG_at_67", 32'(bus.doneBG), 1);
    step();
    chk("s5_plots", 32'(plot_cnt), 64);
    chk("s5_queue_left", 32'(exp_q.size()), 0);

    // 6: three drawChar pulses during an active BG collapse to one CHAR run
    clear_stats();
    tmode = 1'b1;
    bus.xCoordinate = 9'd200;
    bus.yCoordinate = 8'd100;
    push_bg(200, 100);
    push_ch(200, 100);
    pulse(1'b1, 1'b0);
    run_until(5);
    bus.drawChar = 1'b1;
    run_until(20);
    bus.drawChar = 1'b1;
    run_until(40);
    bus.drawChar = 1'b1;
    run_until(67);
    chk("s6_doneBG_at_67", 32'(bus.doneBG), 1);
    run_until(135);
    chk("s6_doneChar_at_135", 32'(bus.doneChar), 1);
    run_until(230);
    chk("s6_done_counts", {done_bg_cnt[15:0], done_ch_cnt[15:0]}, {16'd1, 16'd1});
    chk("s6_plots", 32'(plot_cnt), 96);
    chk("s6_queue_left", 32'(exp_q.size()), 0);
    chk("s6_idle_busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
Name: sprite_drawer

Overview:
- Pixel-writer stage directly downstream of the sprite movement FSM.
- On a one-cycle drawBG or drawChar pulse, it latches the sprite's top-left coordinate.
- It then streams one pixel per cycle to the VGA adapter's write port:
  - drawBG: background-ROM pixels over the sprite rectangle, erasing the sprite.
  - drawChar: character-ROM pixels, skipping transparent ones.
- It returns a one-cycle doneBG or doneChar pulse, which the movement FSM waits on.

Parameters:
- SPR_W, 8, sprite width in pixels (power of 2).
- SPR_H, 8, sprite height in pixels (power of 2).
- COLOUR_W, 3, colour bits per pixel.
- TRANSPARENT, 3'b000, character colour that is not plotted.
- SCREEN_W, 320, visible width.
- SCREEN_H, 240, visible height.

Ports:
- clock  in  1  system clock; all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- drawBG  in  1  one-cycle request: redraw background under the sprite.
- drawChar  in  1  one-cycle request: draw the character sprite.
- xCoordinate  in  9  sprite top-left X, sampled at request acceptance.
- yCoordinate  in  8  sprite top-left Y, sampled at request acceptance.
- bgAddr  out  17  background ROM address = y*320 + x.
- bgColour  in  COLOUR_W  background ROM data, valid 1 cycle after bgAddr.
- charAddr  out  log2(SPR_W*SPR_H)  character ROM address = row*SPR_W + col.
- charColour  in  COLOUR_W  character ROM data, valid 1 cycle after charAddr.
- xOut  out  9  VGA pixel X.
- yOut  out  8  VGA pixel Y.
- colour  out  COLOUR_W  VGA pixel colour.
- plot  out  1  VGA write enable.
- doneBG  out  1  one-cycle pulse after the last BG pixel.
- doneChar  out  1  one-cycle pulse after the last char pixel.
- busy  out  1  high from request acceptance through the done pulse.

Behaviour:
- Reset (async, resetn=0): state IDLE; counters, pending flags, latched coordinates, all outputs = 0.
- Reset mid-operation aborts immediately: no done pulse, pending requests discarded.

States:
- IDLE:
  - Pending or live drawBG → LOAD(mode=BG).
  - Else pending or live drawChar → LOAD(mode=CHAR).
  - BG has priority when both are present.
- LOAD (1 cycle): latch xCoordinate/yCoordinate into X0/Y0, clear col/row counters, clear the pending flag for the mode → SCAN.
- SCAN:
  - Each cycle, issue a ROM address for (col,row), then advance col; col wraps at SPR_W-1 and increments row.
  - After issuing (SPR_W-1, SPR_H-1) → FLUSH.
- FLUSH (1 cycle): the final pipelined pixel is written → DONE.
- DONE (1 cycle): pulse doneBG or doneChar per mode → IDLE.

Pipeline and output timing:
- One register stage aligns X0+col, Y0+row, and mode with the ROM data.
- plot, xOut, yOut and colour are registered; the pixel issued at cycle n appears at cycle n+1.
- Latency from request pulse to done pulse = SPR_W*SPR_H + 3 cycles (LOAD + SCAN + FLUSH + DONE); 67 with defaults.
- busy = (state != IDLE).

Plot rules:
- BG mode: plot=1 with colour=bgColour.
- CHAR mode: plot=1 only when charColour != TRANSPARENT.
- Clipping: any pixel with X0+col >= SCREEN_W or Y0+row >= SCREEN_H gets plot=0. Its cycle is still consumed, so latency is fixed.
- Sums are computed at 10/9 bits to detect overflow; the wrapped value is never plotted.
- bgAddr is computed from clipped-safe coordinates: for a clipped pixel it is held at 0.

Request handling:
- Requests arriving while busy set a sticky pending flag (one per type); duplicates of the same type collapse.
- Coordinates are sampled in LOAD, not at the pulse. The movement FSM holds X/Y stable until done.
- Simultaneous drawBG and drawChar in IDLE: BG runs first, CHAR runs back-to-back after its doneBG, with no extra IDLE cycle beyond the one transition cycle.
- plot=0 and colour=0 in IDLE, LOAD and DONE.

Test Plan:
1. Reset, then drawBG pulse with X=96, Y=222:
   - busy rises the next cycle.
   - 64 plot pulses covering x 96..103, y 222..229.
   - bgAddr first = 222*320+96 = 71136.
   - doneBG exactly 67 cycles after the pulse; doneChar stays 0.
2. drawChar at X=10, Y=10 with the ROM returning TRANSPARENT at even addresses:
   - Exactly 32 plots, colours matching the ROM, pixels row-major from (10,10).
   - doneChar at cycle 67.
3. drawBG and drawChar pulsed in the same cycle:
   - BG sequence completes with doneBG, then the CHAR sequence runs.
   - doneChar 1+67 cycles after doneBG; no pixel is lost or duplicated.
4. Clipping, drawChar at X=316, Y=236:
   - Only a 4x4 block (x 316..319, y 236..239) is plotted.
   - doneChar still at cycle 67.
5. Reset mid-operation: assert resetn=0 at cycle 30 of a drawBG:
   - plot, busy and done go to 0 asynchronously.
   - No doneBG afterwards; a fresh drawBG after release behaves as scenario 1.
6. drawChar pulsed 3 times during an active BG:
   - Exactly one CHAR sequence follows.
   - Exactly one doneBG and one doneChar pulse total.
